// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, stall, flush and N-source operand forwarding control for the RV32I core.
// Optional performance counters are enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    imem_ready,
    input  logic                    ex_mem_req,
    input  logic                    ex_take_branch,
    input  logic [4:0]              ex_rs1_addr,
    input  logic [4:0]              ex_rs2_addr,
    input  logic [XLEN-1:0]         ex_rs1_data,
    input  logic [XLEN-1:0]         ex_rs2_data,
    input  logic [NUM_FWD-1:0]      fwd_write_en,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_addr,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic [XLEN-1:0]         ex_fwd_rs1_data,
    output logic [XLEN-1:0]         ex_fwd_rs2_data,
    output logic                    if_stall,
    output logic                    id_stall,
    output logic                    ex_stall,
    output logic                    id_flush,
    output logic                    ex_flush,
    output logic                    mem_busy
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_stall_cycles,
    output logic [31:0]             perf_flush_count
`endif
);

    localparam int CW = $clog2(MEM_LATENCY) + 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_LATENCY - 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic          w_branch;

    // Lowest-index matching source wins; x0 always reads the register-file value.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [4:0]              addr,
        input logic [XLEN-1:0]         rf_val,
        input logic [NUM_FWD-1:0]      we,
        input logic [5*NUM_FWD-1:0]    rd,
        input logic [XLEN*NUM_FWD-1:0] data
    );
        logic [XLEN-1:0] v;
        logic            hit;
        v   = rf_val;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit && we[i] && (addr != 5'd0) && (rd[5*i +: 5] == addr)) begin
                v   = data[XLEN*i +: XLEN];
                hit = 1'b1;
            end
        end
        return v;
    endfunction

    always_comb begin
        ex_fwd_rs1_data = fwd_pick(ex_rs1_addr, ex_rs1_data, fwd_write_en, fwd_rd_addr, fwd_data);
        ex_fwd_rs2_data = fwd_pick(ex_rs2_addr, ex_rs2_data, fwd_write_en, fwd_rd_addr, fwd_data);
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_branch       = 1'b0;
        if_stall       = 1'b0;
        id_stall       = 1'b0;
        ex_stall       = 1'b0;
        id_flush       = 1'b0;
        ex_flush       = 1'b0;
        mem_busy       = 1'b0;
        if (rst) begin
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_MEM_WAIT: begin
                    if_stall       = 1'b1;
                    id_stall       = 1'b1;
                    ex_stall       = 1'b1;
                    mem_busy       = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                    if (r_wait_cnt == CW'(1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    if (ex_take_branch) begin
                        w_branch = 1'b1;
                        id_flush = 1'b1;
                        ex_flush = 1'b1;
                    end else if (!imem_ready) begin
                        if_stall = 1'b1;
                        id_flush = 1'b1;
                    end
                    if (ex_mem_req && (MEM_LATENCY > 1)) begin
                        w_state_nxt    = ST_MEM_WAIT;
                        w_wait_cnt_nxt = WAIT_INIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ex_mem_req && ex_take_branch));
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (if_stall || ex_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_branch) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_count  = r_perf_flush;
`else
    logic w_branch_unused;
    assign w_branch_unused = w_branch;
`endif

endmodule
